m3_drive_sequencer: RTL and testbench

- Command sequencer in front of the 3-phase power/speed calculation block.
- Turns one-cycle operator command pulses into that block's level controls: start, force-stop, rotation direction, speed INC/DEC and power INC/DEC.
- Adds soft-start ramping, decelerate-before-reverse, a round-tick watchdog and fault latching.
- Synchronised to the calc block's per-round tick.

---
 rtl/m3_drive_sequencer.sv | 143 ++++++++++++++
 tb/tb_m3_drive_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m3_drive_sequencer.sv
// m3_drive_sequencer: turns operator command pulses into level controls for the 3-phase calc block
//   clkI/nRstI        clock, asynchronous active-low reset
//   cmd*I             one-cycle command pulses (start, stop, reverse, faster, slower, stronger, weaker)
//   roundTickI        per-round pulse from the calc block; atMinSpeedI slowest-speed level; faultI overcurrent level
//   m3*O / m3*o       registered controls to the calc block; stateO state code; faultO latched fault
module m3_drive_sequencer #(
  parameter int RAMP_ROUNDS = 8,
  parameter int STEP_ROUNDS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       cmdStartI,
  input  logic       cmdStopI,
  input  logic       cmdReverseI,
  input  logic       cmdFasterI,
  input  logic       cmdSlowerI,
  input  logic       cmdStrongerI,
  input  logic       cmdWeakerI,
  input  logic       roundTickI,
  input  logic       atMinSpeedI,
  input  logic       faultI,
  output logic       m3startO,
  output logic       m3forceStopO,
  output logic       m3invRotateO,
  output logic       m3speedINCo,
  output logic       m3speedDECo,
  output logic       m3powerINCo,
  output logic       m3powerDECo,
  output logic [2:0] stateO,
  output logic       faultO
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, DECEL = 3'd3, REVERSE = 3'd4, FAULT = 3'd5} state_t;
  state_t state, s_n;
  logic [7:0] ramp_cnt, ramp_n;
  logic [3:0] hold_cnt, hold_n;
  logic [HW-1:0] rev_cnt, rc_n;
  logic [25:0] wd_cnt, wd_n;
  logic hold_up, up_n, rev_pend, rp_n, inv_n;
  logic running, wd_exp, pwr_ok;
  assign stateO = state;
  assign running = state inside {RAMP, RUN, DECEL};
  // a tick arriving in the last allowed cycle still rescues the watchdog
  assign wd_exp = running && !roundTickI && wd_cnt == 26'(WDOG_CYCLES - 1);
  // stop and reverse outrank the power/speed commands issued in the same cycle
  assign pwr_ok = (state == RAMP || state == RUN) && !faultI && !wd_exp && !cmdStopI && !cmdReverseI;
  always_comb begin
    s_n = state;
    ramp_n = ramp_cnt;
    hold_n = hold_cnt;
    up_n = hold_up;
    rp_n = rev_pend;
    rc_n = rev_cnt;
    inv_n = m3invRotateO;
    if (faultI || wd_exp) begin
      s_n = FAULT;
      ramp_n = '0;
      hold_n = '0;
      rp_n = 1'b0;
      rc_n = '0;
    end else begin
      case (state)
        IDLE: if (cmdStartI) begin
          s_n = RAMP;
          ramp_n = 8'(RAMP_ROUNDS);
        end
        RAMP, RUN: if (cmdStopI || cmdReverseI) begin
          s_n = DECEL;
          rp_n = !cmdStopI;
          hold_n = '0;
        end else if (state == RAMP) begin
          if (roundTickI) begin
            ramp_n = ramp_cnt - 8'd1;
            s_n = ramp_cnt == 8'd1 ? RUN : RAMP;
          end
        end else if (cmdFasterI != cmdSlowerI) begin
          hold_n = 4'(STEP_ROUNDS);
          up_n = cmdFasterI;
        end else if (roundTickI && hold_cnt != 4'd0) begin
          hold_n = hold_cnt - 4'd1;
        end
        DECEL: begin
          rp_n = cmdStopI ? 1'b0 : cmdReverseI ? 1'b1 : rev_pend;
          if (roundTickI && atMinSpeedI) begin
            s_n = rp_n ? REVERSE : IDLE;
            inv_n = rp_n ? !m3invRotateO : m3invRotateO;
            rc_n = HW'(HOLD_CYCLES - 1);
          end
        end
        REVERSE: if (cmdStopI) begin
          s_n = IDLE;
          rp_n = 1'b0;
          rc_n = '0;
        end else if (rev_cnt == '0) begin
          s_n = RAMP;
          ramp_n = 8'(RAMP_ROUNDS);
          rp_n = 1'b0;
        end else begin
          rc_n = rev_cnt - HW'(1);
        end
        FAULT: if (cmdStopI) s_n = IDLE;
        default: s_n = IDLE;
      endcase
    end
    wd_n = (s_n == state && running && !roundTickI) ? wd_cnt + 26'd1 : '0;
  end
  always_ff @(posedge clkI or negedge nRstI)
    if (!nRstI) begin
      state <= IDLE;
      ramp_cnt <= '0;
      hold_cnt <= '0;
      hold_up <= 1'b0;
      rev_pend <= 1'b0;
      rev_cnt <= '0;
      wd_cnt <= '0;
      m3startO <= 1'b0;
      m3forceStopO <= 1'b0;
      m3invRotateO <= 1'b0;
      m3speedINCo <= 1'b0;
      m3speedDECo <= 1'b0;
      m3powerINCo <= 1'b0;
      m3powerDECo <= 1'b0;
      faultO <= 1'b0;
    end else begin
      state <= s_n;
      ramp_cnt <= ramp_n;
      hold_cnt <= hold_n;
      hold_up <= up_n;
      rev_pend <= rp_n;
      rev_cnt <= rc_n;
      wd_cnt <= wd_n;
      m3startO <= s_n inside {RAMP, RUN, DECEL};
      m3forceStopO <= s_n == FAULT;
      m3invRotateO <= inv_n;
      m3speedINCo <= s_n == RAMP || (s_n == RUN && hold_n != 4'd0 && up_n);
      m3speedDECo <= s_n == DECEL || (s_n == RUN && hold_n != 4'd0 && !up_n);
      m3powerINCo <= pwr_ok && cmdStrongerI && !cmdWeakerI;
      m3powerDECo <= pwr_ok && cmdWeakerI && !cmdStrongerI;
      faultO <= s_n == FAULT;
    end
endmodule

// File: tb/tb_m3_drive_sequencer.sv
// tb_m3_drive_sequencer: randomized and directed bench checking m3_drive_sequencer against a behavioural model
module tb_m3_drive_sequencer;
  localparam int RAMP = 2, STEP = 4, HOLD = 3, WDOG = 100;
  logic clk = 0, nrst = 0;
  logic start = 0, stop = 0, rev = 0, faster = 0, slower = 0, stronger = 0, weaker = 0;
  logic tick = 0, at_min = 0, fault = 0;
  logic m_start, m_fstop, m_inv, m_inc, m_dec, m_pinc, m_pdec, m_fault;
  logic [2:0] m_state;
  int total = 0, bad = 0;
  int mode, ramp_left, step_left, hold_left, quiet;
  bit step_up, rev_want, dir, e_pinc, e_pdec;
  m3_drive_sequencer #(.RAMP_ROUNDS(RAMP), .STEP_ROUNDS(STEP), .HOLD_CYCLES(HOLD), .WDOG_CYCLES(WDOG)) dut (
    .clkI(clk), .nRstI(nrst), .cmdStartI(start), .cmdStopI(stop), .cmdReverseI(rev),
    .cmdFasterI(faster), .cmdSlowerI(slower), .cmdStrongerI(stronger), .cmdWeakerI(weaker),
    .roundTickI(tick), .atMinSpeedI(at_min), .faultI(fault),
    .m3startO(m_start), .m3forceStopO(m_fstop), .m3invRotateO(m_inv), .m3speedINCo(m_inc),
    .m3speedDECo(m_dec), .m3powerINCo(m_pinc), .m3powerDECo(m_pdec), .stateO(m_state), .faultO(m_fault));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mode = 0; ramp_left = 0; step_left = 0; hold_left = 0; quiet = 0;
    step_up = 0; rev_want = 0; dir = 0; e_pinc = 0; e_pdec = 0;
  endtask
  // mode numbers: 0 idle, 1 soft start, 2 running, 3 slowing down, 4 reversing pause, 5 fault
  task automatic model_step();
    bit moving, dog, cmd_ok;
    int nm;
    moving = mode >= 1 && mode <= 3;
    dog = moving && !tick && quiet + 1 >= WDOG;
    cmd_ok = (mode == 1 || mode == 2) && !fault && !dog && !stop && !rev;
    e_pinc = cmd_ok && stronger && !weaker;
    e_pdec = cmd_ok && weaker && !stronger;
    nm = mode;
    if (fault || dog) begin
      nm = 5; ramp_left = 0; step_left = 0; rev_want = 0; hold_left = 0;
    end else if (mode == 0) begin
      if (start) begin nm = 1; ramp_left = RAMP; end
    end else if ((mode == 1 || mode == 2) && (stop || rev)) begin
      nm = 3; rev_want = !stop; step_left = 0;
    end else if (mode == 1) begin
      if (tick) begin
        ramp_left--;
        if (ramp_left == 0) nm = 2;
      end
    end else if (mode == 2) begin
      if (faster && !slower) begin step_left = STEP; step_up = 1; end
      else if (slower && !faster) begin step_left = STEP; step_up = 0; end
      else if (tick && step_left > 0) step_left--;
    end else if (mode == 3) begin
      if (stop) rev_want = 0;
      else if (rev) rev_want = 1;
      if (tick && at_min) begin
        if (rev_want) begin nm = 4; dir = !dir; hold_left = HOLD; end
        else nm = 0;
      end
    end else if (mode == 4) begin
      if (stop) begin nm = 0; rev_want = 0; end
      else begin
        hold_left--;
        if (hold_left == 0) begin nm = 1; ramp_left = RAMP; rev_want = 0; end
      end
    end else if (stop) nm = 0;
    quiet = (nm == mode && moving && !tick) ? quiet + 1 : 0;
    mode = nm;
  endtask
  task automatic compare_all();
    check("state", int'(m_state), mode);
    check("start", int'(m_start), int'(mode >= 1 && mode <= 3));
    check("force_stop", int'(m_fstop), int'(mode == 5));
    check("fault_out", int'(m_fault), int'(mode == 5));
    check("inv_rotate", int'(m_inv), int'(dir));
    check("speed_inc", int'(m_inc), int'(mode == 1 || (mode == 2 && step_left > 0 && step_up)));
    check("speed_dec", int'(m_dec), int'(mode == 3 || (mode == 2 && step_left > 0 && !step_up)));
    check("power_inc", int'(m_pinc), int'(e_pinc));
    check("power_dec", int'(m_pdec), int'(e_pdec));
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    {start, stop, rev, faster, slower, stronger, weaker, tick} = '0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; cycle();
      idle(2);
    end
  endtask
  task automatic to_run();
    start = 1; cycle();
    tick = 1; cycle();
    tick = 1; cycle();
  endtask
  initial begin
    int gap;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
    compare_all();
    check("reset_state", int'(m_state), 0);
    start = 1; cycle();
    check("start_state", int'(m_state), 1);
    check("start_inc", int'({m_start, m_inc}), 3);
    tick = 1; cycle();
    tick = 1; cycle();
    check("ramp_done_state", int'(m_state), 2);
    check("ramp_done_inc", int'(m_inc), 0);
    faster = 1; cycle();
    ticks(3);
    check("faster_held", int'(m_inc), 1);
    ticks(1);
    check("faster_released", int'(m_inc), 0);
    faster = 1; slower = 1; cycle();
    check("both_speed", int'({m_inc, m_dec}), 0);
    faster = 1; cycle();
    ticks(2);
    slower = 1; cycle();
    check("slower_replaces", int'({m_inc, m_dec}), 1);
    ticks(3);
    check("slower_held", int'(m_dec), 1);
    ticks(1);
    check("slower_released", int'(m_dec), 0);
    rev = 1; cycle();
    check("decel_state", int'(m_state), 3);
    check("decel_dec", int'(m_dec), 1);
    tick = 1; cycle();
    check("decel_not_min", int'(m_state), 3);
    at_min = 1; tick = 1; cycle();
    at_min = 0;
    check("reverse_state", int'(m_state), 4);
    check("reverse_inv", int'({m_inv, m_start}), 2);
    idle(2);
    check("reverse_hold", int'({m_state, m_start}), 8);
    idle(1);
    check("reverse_done", int'({m_state, m_start}), 3);
    tick = 1; cycle();
    tick = 1; cycle();
    fault = 1; cycle();
    check("fault_entry", int'({m_state, m_fstop, m_fault}), 23);
    stop = 1; cycle();
    check("fault_stop_blocked", int'(m_state), 5);
    fault = 0; cycle();
    stop = 1; cycle();
    check("fault_cleared", int'({m_state, m_fstop, m_fault, m_start}), 0);
    check("inv_kept", int'(m_inv), 1);
    to_run();
    idle(WDOG - 1);
    check("wdog_not_yet", int'(m_state), 2);
    idle(1);
    check("wdog_fault", int'(m_state), 5);
    stop = 1; cycle();
    to_run();
    for (int i = 0; i < 3; i++) begin
      idle(WDOG - 2);
      tick = 1; cycle();
    end
    check("wdog_fed", int'(m_state), 2);
    stronger = 1; weaker = 1; cycle();
    check("both_power", int'({m_pinc, m_pdec}), 0);
    stronger = 1; cycle();
    check("power_pulse", int'(m_pinc), 1);
    idle(1);
    check("power_pulse_end", int'(m_pinc), 0);
    stop = 1; cycle();
    at_min = 1; tick = 1; cycle();
    at_min = 0;
    check("stop_to_idle", int'(m_state), 0);
    stronger = 1; cycle();
    check("idle_power", int'(m_pinc), 0);
    to_run();
    rev = 1; cycle();
    idle(1);
    nrst = 0;
    #1;
    model_reset();
    compare_all();
    check("async_reset", int'({m_state, m_start, m_dec, m_inv}), 0);
    @(posedge clk);
    #1;
    nrst = 1;
    gap = 3;
    for (int i = 0; i < 5000; i++) begin
      start = $urandom_range(0, 9) == 0;
      stop = $urandom_range(0, 59) == 0;
      rev = $urandom_range(0, 39) == 0;
      faster = $urandom_range(0, 14) == 0;
      slower = $urandom_range(0, 14) == 0;
      stronger = $urandom_range(0, 9) == 0;
      weaker = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) at_min = $urandom_range(0, 1) == 1;
      if (fault) fault = $urandom_range(0, 9) != 0;
      else fault = $urandom_range(0, 499) == 0;
      if (gap == 0) begin
        tick = 1;
        gap = $urandom_range(0, 39) == 0 ? 110 : $urandom_range(1, 12);
      end else gap--;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
